// File: rtl/ram_bus_master_pkg.sv
// Shared types and default widths for the RAM bus initiator.
package ram_bus_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF  = 4;

    // Bus phases of the initiator. DRAIN carries the final read beat out of
    // the RAM; TURN is a dead cycle so the RAM releases the data bus before
    // the master can drive it again.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        TURN  = 3'd4
    } ram_bus_state_t;

endpackage

// File: rtl/ram_bus_master_if.sv
// Client handshake and RAM control signals of the bus initiator.
// The tri-state data bus is a plain inout on the master itself.
interface ram_bus_master_if
    import ram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
);
    // client request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;

    // client write beat channel
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    // client read return channel
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    // RAM control
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;

    // Initiator view.
    modport master (
        input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, busy,
        output mem_addr, mem_cs, mem_we, mem_oe
    );

    // Client / RAM view.
    modport slave (
        output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, busy,
        input  mem_addr, mem_cs, mem_we, mem_oe
    );

endinterface

// File: rtl/ram_bus_master_burst_counter.sv
// Loadable word-address incrementer with a down-counting beat counter.
// last_o flags the final beat of the burst (beats remaining == 0).
module ram_burst_counter
    import ram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  adv_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;

    // Load has priority over advance; address wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        addr_d  = addr_q;
        beats_d = beats_q;
        if (load_i) begin
            addr_d  = addr_i;
            beats_d = len_i;
        end else if (adv_i) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            beats_d = beats_q - LEN_WIDTH'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (beats_q == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Burst initiator for a single-port synchronous RAM. Accepts valid/ready
// requests, drives single or incrementing bursts, owns the data bus only
// while writing and returns read beats on a registered strobe.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_bus_master_if.master      bus,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    ram_bus_state_t        state_q, state_d;
    logic                  running_q;    // low while in reset and for the first cycle after
    logic                  cap_q;        // previous cycle was a READ address cycle
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  req_ready;
    logic                  wr_ready;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic                  drive_bus;
    logic                  cnt_load;
    logic                  cnt_adv;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cnt_last;

    ram_burst_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .addr_i (bus.req_addr),
        .len_i  (bus.req_len),
        .adv_i  (cnt_adv),
        .addr_o (cur_addr),
        .last_o (cnt_last)
    );

    // Next-state and bus strobes. In READ the counter stops on the last
    // beat so DRAIN keeps presenting the final address.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        drive_bus = 1'b0;
        cnt_load  = 1'b0;
        cnt_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = running_q;
                if (running_q && bus.req_valid) begin
                    cnt_load = 1'b1;
                    state_d  = bus.req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready  = 1'b1;
                mem_we    = 1'b1;
                mem_cs    = bus.wr_valid;
                drive_bus = 1'b1;
                if (bus.wr_valid) begin
                    cnt_adv = 1'b1;
                    if (cnt_last) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                mem_cs = 1'b1;
                mem_oe = 1'b1;
                if (cnt_last) begin
                    state_d = DRAIN;
                end else begin
                    cnt_adv = 1'b1;
                end
            end
            DRAIN: begin
                mem_cs  = 1'b1;
                mem_oe  = 1'b1;
                state_d = TURN;
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; running_q holds off acceptance until reset is fully released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= 1'b1;
        end
    end

    // Read capture: the RAM answers one cycle after each READ address, so
    // the bus is sampled at the end of the cycle following a READ cycle and
    // presented as a one-cycle strobe in the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            cap_q      <= (state_q == READ);
            rd_valid_q <= cap_q;
            if (cap_q) begin
                rd_data_q <= mem_data;
            end
        end
    end

    assign mem_data     = drive_bus ? bus.wr_data : {DATA_WIDTH{1'bz}};

    assign bus.req_ready = req_ready;
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_addr  = cur_addr;
    assign bus.mem_cs    = mem_cs;
    assign bus.mem_we    = mem_we;
    assign bus.mem_oe    = mem_oe;

endmodule

// File: tb/tb_ram_bus_master.sv
// Scoreboard bench for ram_bus_master with a behavioural synchronous RAM.
module tb_ram_bus_master;
    import ram_bus_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
    wire [DW-1:0] mem_data;

    ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_data (mem_data)
    );

    // Synchronous RAM: latches the read address at the clock edge, drives
    // the word in the following cycle while mem_oe is high.
    logic [DW-1:0] ram [0:255];
    logic [AW-1:0] ram_raddr = '0;
    logic          ram_lat = 1'b0;
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr] <= mem_data;
        ram_lat <= bus.mem_cs && !bus.mem_we;
        if (bus.mem_cs && !bus.mem_we) ram_raddr <= bus.mem_addr;
    end
    assign mem_data = (ram_lat && bus.mem_oe) ? ram[ram_raddr] : {DW{1'bz}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Undriven bus: 4-state tools show z, 2-state tools read 0.
    task automatic chk_hiz(input string nm);
        tests++;
        if (!(mem_data === {DW{1'bz}} || mem_data === {DW{1'b0}})) begin
            fails++;
            $display("FAIL %s: bus driven with 0x%0h, expected high-Z", nm, mem_data);
        end
    endtask

    // Monitor: every read strobe must match the next expected beat and cycle.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got rd_data 0x%0h, expected no rd_valid (cyc %0d)",
                         bus.rd_data, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("[TB] rd beat data=0x%0h cyc=%0d (exp 0x%0h @%0d)", bus.rd_data, cyc, e.data, e.cyc);
                chk("rd_data", 32'(bus.rd_data), 32'(e.data));
                chk("rd_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic req(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       output int acc);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_len   = len;
        acc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        bus.req_valid = 1'b0;
        if (acc < 0) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got no acceptance, expected req_ready within 50 cycles");
        end else begin
            $display("[TB] req we=%0d addr=0x%0h len=%0d accepted cyc=%0d", we, addr, len, acc);
        end
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [DW-1:0] d [8], input int stall_at);
        int acc;
        logic [AW-1:0] a;
        req(1'b1, addr, len, acc);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            if (i == stall_at) begin
                bus.wr_valid = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    chk("stall_cs", 32'(bus.mem_cs), 32'd0);
                    chk("stall_addr", 32'(bus.mem_addr), 32'(a));
                    @(posedge clk);
                    #1;
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = d[i];
            @(negedge clk);
            chk("wr_cs", 32'(bus.mem_cs), 32'd1);
            chk("wr_addr", 32'(bus.mem_addr), 32'(a));
            chk("wr_bus", 32'(mem_data), 32'(d[i]));
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'hC3;
        chk("wr_done_ready", 32'(bus.req_ready), 32'd1);
        $display("[TB] write burst addr=0x%0h beats=%0d done", addr, int'(len) + 1);
    endtask

    task automatic rd_issue(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [DW-1:0] d [8], input int npush, output int acc);
        exp_t e;
        req(1'b0, addr, len, acc);
        for (int i = 0; i < npush; i++) begin
            e.data = d[i];
            e.cyc  = acc + 2 + i;
            sb_q.push_back(e);
        end
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            input logic [DW-1:0] d [8]);
        int acc;
        int rdy_cyc;
        rd_issue(addr, len, d, int'(len) + 1, acc);
        rdy_cyc = -1;
        for (int n = 0; n < 40; n++) begin
            if (bus.req_ready) begin
                rdy_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rd_ready_cycle", rdy_cyc, acc + int'(len) + 3);
        chk("rd_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        int acc_r;
        int nval;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'hC3;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_cs", 32'(bus.mem_cs), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk_hiz("rst_bus");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // single write then read
        wr_burst(8'h10, 4'd0, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1);
        chk("ram_10", 32'(ram[8'h10]), 32'hA5);
        rd_burst(8'h10, 4'd0, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

        // 4-beat burst
        wr_burst(8'h20, 4'd3, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, -1);
        rd_burst(8'h20, 4'd3, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00});

        // address wrap-around
        wr_burst(8'hFE, 4'd2, '{8'h07, 8'h08, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1);
        chk("ram_FE", 32'(ram[8'hFE]), 32'h07);
        chk("ram_FF", 32'(ram[8'hFF]), 32'h08);
        chk("ram_00", 32'(ram[8'h00]), 32'h09);
        rd_burst(8'hFE, 4'd2, '{8'h07, 8'h08, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

        // write stall before the third beat
        wr_burst(8'h40, 4'd3, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        chk("ram_40", 32'(ram[8'h40]), 32'h11);
        chk("ram_41", 32'(ram[8'h41]), 32'h22);
        chk("ram_42", 32'(ram[8'h42]), 32'h33);
        chk("ram_43", 32'(ram[8'h43]), 32'h44);

        // read followed immediately by a write: check the TURN cycle
        rd_issue(8'h10, 4'd0, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, acc_r);
        fork
            wr_burst(8'h50, 4'd0, '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1);
            begin
                while (cyc != acc_r + 2) @(negedge clk);
                chk("turn_cs", 32'(bus.mem_cs), 32'd0);
                chk("turn_oe", 32'(bus.mem_oe), 32'd0);
                chk("turn_busy", 32'(bus.busy), 32'd1);
                chk("turn_ready", 32'(bus.req_ready), 32'd0);
                chk_hiz("turn_bus");
            end
        join
        chk("ram_50", 32'(ram[8'h50]), 32'h5A);
        chk("turn_sb_empty", sb_q.size(), 0);

        // reset during beat 2 of an 8-beat read
        rd_issue(8'h20, 4'd7, '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, acc_r);
        while (cyc < acc_r + 3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sb_empty", sb_q.size(), 0);
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("abort_rd_data", 32'(bus.rd_data), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_cs", 32'(bus.mem_cs), 32'd0);
        chk("abort_oe", 32'(bus.mem_oe), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd0);
        chk_hiz("abort_bus");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.rd_valid) nval++;
        end
        chk("abort_no_rd_valid", nval, 0);
        chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
        chk("abort_busy_after", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
